uart_prog_loader: RTL and testbench

//  UART-driven program loader: receives a framed word image on a serial RX pin and writes it

---
 rtl/uart_prog_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART (8N1) program loader: parses A5/LEN/data[/CKSUM] frames and writes RAM words,
// holding the CPU in reset until the image is complete. Checksum byte: UART_PROG_LOADER_CKSUM_EN.
module uart_prog_loader #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    output logic              ram_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);
    localparam int BIT_DIV = CLK_HZ / BAUD;
    localparam int CNT_W   = $clog2(BIT_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_DIV / 2 - 1);
    localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA_HI, L_DATA_LO,
`ifdef UART_PROG_LOADER_CKSUM_EN
        L_CKSUM,
`endif
        L_DONE, L_ERR
    } ld_state_t;

    rx_state_t        rx_state;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             byte_valid, frame_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the synchroniser resets to the idle level so leaving reset never looks like a start bit.
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        baud_cnt <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt   <= '0;
                        byte_valid <= rx_sync;
                        frame_err  <= !rx_sync;
                        rx_state   <= RX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    ld_state_t     state;
    logic [7:0]    len_hi, data_hi;
    logic [15:0]   len;
    logic [ADDR_W:0] index;
    logic [ADDR_W:0] next_index;
    logic [15:0]   frame_len;
    logic          last_word;
`ifdef UART_PROG_LOADER_CKSUM_EN
    logic [7:0]    cksum;
`endif

    assign frame_len  = {len_hi, rx_shift};
    assign next_index = index + 1'b1;
    assign last_word  = (17'(next_index) == {1'b0, len});
    assign busy       = !(state inside {L_IDLE, L_DONE, L_ERR});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= L_IDLE;
            len_hi     <= '0;
            data_hi    <= '0;
            len        <= '0;
            index      <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
`ifdef UART_PROG_LOADER_CKSUM_EN
            cksum      <= '0;
`endif
        end else begin
            // NOTE: ram_we defaults low every cycle so a write is exactly one clk wide.
            ram_we <= 1'b0;
            if (frame_err && busy) begin
                state <= L_ERR;
                err   <= 1'b1;
            end else if (byte_valid) begin
                case (state)
                    L_IDLE, L_DONE, L_ERR: begin
                        if (rx_shift == 8'hA5) begin
                            state      <= L_LEN_HI;
                            index      <= '0;
                            word_count <= '0;
                            done       <= 1'b0;
                            err        <= 1'b0;
                            cpu_hold   <= 1'b1;
`ifdef UART_PROG_LOADER_CKSUM_EN
                            cksum      <= '0;
`endif
                        end
                    end
                    L_LEN_HI: begin
                        len_hi <= rx_shift;
                        state  <= L_LEN_LO;
                    end
                    L_LEN_LO: begin
                        len <= frame_len;
                        if ({1'b0, frame_len} > MAX_LEN) begin
                            state <= L_ERR;
                            err   <= 1'b1;
                        end else if (frame_len == 16'd0) begin
`ifdef UART_PROG_LOADER_CKSUM_EN
                            state <= L_CKSUM;
`else
                            state    <= L_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state <= L_DATA_HI;
                        end
                    end
                    L_DATA_HI: begin
                        data_hi <= rx_shift;
`ifdef UART_PROG_LOADER_CKSUM_EN
                        cksum   <= cksum ^ rx_shift;
`endif
                        state   <= L_DATA_LO;
                    end
                    L_DATA_LO: begin
                        ram_we     <= 1'b1;
                        ram_addr   <= index[ADDR_W-1:0];
                        ram_wdata  <= {data_hi, rx_shift};
                        index      <= next_index;
                        word_count <= word_count + 16'd1;
`ifdef UART_PROG_LOADER_CKSUM_EN
                        cksum      <= cksum ^ rx_shift;
                        state      <= last_word ? L_CKSUM : L_DATA_HI;
`else
                        if (last_word) begin
                            state    <= L_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= L_DATA_HI;
                        end
`endif
                    end
`ifdef UART_PROG_LOADER_CKSUM_EN
                    L_CKSUM: begin
                        if (rx_shift == cksum) begin
                            state    <= L_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= L_ERR;
                            err   <= 1'b1;
                        end
                    end
`endif
                    default: state <= L_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: a frame-level model predicts writes and status; directed frames
// plus literal expectations pin the model. Works with or without UART_PROG_LOADER_CKSUM_EN.
module tb_uart_prog_loader;
    localparam int CLK_HZ  = 1_000_000;
    localparam int BAUD    = 100_000;
    localparam int ADDR_W  = 4;
    localparam int BIT_DIV = CLK_HZ / BAUD;
    localparam int GAP     = 4;
`ifdef UART_PROG_LOADER_CKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx = 1'b1;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic              ram_we, cpu_hold, busy, done, err;
    logic [15:0]       word_count;

    uart_prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Frame-level model: position within the frame, running XOR, expected write queue.
    typedef struct packed { logic [ADDR_W-1:0] addr; logic [15:0] data; } wr_t;
    typedef logic [7:0] byte_q_t[$];

    wr_t        exp_wr[$];
    wr_t        got;
    bit         m_in, m_done, m_err, m_hold;
    int         m_pos, m_len, m_after, m_words;
    logic [7:0] m_lhi, m_dhi, m_x;
    int         n_writes = 0;

    function automatic void model_finish();
        m_in = 1'b0; m_done = 1'b1; m_hold = 1'b0;
    endfunction

    function automatic void model_abort();
        m_in = 1'b0; m_err = 1'b1;
    endfunction

    function automatic void model_reset();
        m_in = 1'b0; m_done = 1'b0; m_err = 1'b0; m_hold = 1'b0; m_words = 0;
        exp_wr.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (!m_in) begin
            if (b == 8'hA5) begin
                m_in = 1'b1; m_pos = 1; m_words = 0; m_x = 8'h00;
                m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
            end
        end else if (m_pos == 1) begin
            m_lhi = b; m_pos = 2;
        end else if (m_pos == 2) begin
            m_len = {16'h0, m_lhi, b}; m_pos = 3; m_after = 0;
            if (m_len > (1 << ADDR_W)) model_abort();
            else if (m_len == 0 && !CKSUM_EN) model_finish();
        end else if (m_after < 2 * m_len) begin
            m_x ^= b;
            if (m_after % 2 == 0) begin
                m_dhi = b;
            end else begin
                exp_wr.push_back(wr_t'{addr: m_words[ADDR_W-1:0], data: {m_dhi, b}});
                m_words++;
                if (m_words == m_len && !CKSUM_EN) model_finish();
            end
            m_after++;
        end else begin
            if (b == m_x) model_finish();
            else model_abort();
        end
    endfunction

    // Every write strobe must match the next predicted write, in order.
    always @(negedge clk) begin
        if (ram_we) begin
            n_writes++;
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: actual addr=0x%0h data=0x%0h expected=no write", ram_addr, ram_wdata);
            end else begin
                got = exp_wr.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(got.addr));
                check("wr_data", 32'(ram_wdata), 32'(got.data));
            end
        end
    end

    task automatic check_status(input string tag);
        check({tag, " done"}, 32'(done), 32'(m_done));
        check({tag, " err"}, 32'(err), 32'(m_err));
        check({tag, " cpu_hold"}, 32'(cpu_hold), 32'(m_hold));
        check({tag, " busy"}, 32'(busy), 32'(m_in));
        check({tag, " word_count"}, 32'(word_count), 32'(m_words));
        check({tag, " pending_writes"}, 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) model_byte(b);
        else if (m_in) model_abort();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
        rx = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_seq(input byte_q_t bs, input string tag);
        foreach (bs[i]) begin
            send_byte(bs[i], 1'b1);
            check_status($sformatf("%s[%0d]", tag, i));
        end
    endtask

    task automatic glitch(input int n);
        rx = 1'b0;
        repeat (n) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_DIV) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, " ram_wdata"}, 32'(ram_wdata), 32'd0);
        check({tag, " ram_we"}, 32'(ram_we), 32'd0);
        check({tag, " cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
        check({tag, " word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        byte_q_t q;
        int w0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 1: two-word image with correct checksum
        w0 = n_writes;
        q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_seq(q, "t1");
        check("t1 lit writes", 32'(n_writes - w0), 32'd2);
        check("t1 lit done", 32'(done), 32'd1);
        check("t1 lit err", 32'(err), 32'd0);
        check("t1 lit cpu_hold", 32'(cpu_hold), 32'd0);
        check("t1 lit word_count", 32'(word_count), 32'd2);
        check("t1 lit ram_addr", 32'(ram_addr), 32'd1);
        check("t1 lit ram_wdata", 32'(ram_wdata), 32'hABCD);

        // 2: same frame, bad checksum
        w0 = n_writes;
        q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_seq(q, "t2");
        check("t2 lit writes", 32'(n_writes - w0), 32'd2);
`ifdef UART_PROG_LOADER_CKSUM_EN
        check("t2 lit err", 32'(err), 32'd1);
        check("t2 lit done", 32'(done), 32'd0);
        check("t2 lit cpu_hold", 32'(cpu_hold), 32'd1);
`else
        check("t2 lit err", 32'(err), 32'd0);
        check("t2 lit done", 32'(done), 32'd1);
        check("t2 lit cpu_hold", 32'(cpu_hold), 32'd0);
`endif

        // 3: leading junk, empty image
        w0 = n_writes;
        q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_seq(q, "t3");
        check("t3 lit writes", 32'(n_writes - w0), 32'd0);
        check("t3 lit done", 32'(done), 32'd1);
        check("t3 lit word_count", 32'(word_count), 32'd0);

        // 4: oversize length, then a good one-word frame
        w0 = n_writes;
        q = '{8'hA5, 8'h00, 8'h11};
        send_seq(q, "t4a");
        check("t4a lit err", 32'(err), 32'd1);
        check("t4a lit busy", 32'(busy), 32'd0);
        check("t4a lit writes", 32'(n_writes - w0), 32'd0);
        q = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
        send_seq(q, "t4b");
        check("t4b lit done", 32'(done), 32'd1);
        check("t4b lit err", 32'(err), 32'd0);
        check("t4b lit ram_addr", 32'(ram_addr), 32'd0);
        check("t4b lit ram_wdata", 32'(ram_wdata), 32'hBEEF);

        // 5: framing error mid-frame, then rx glitches
        q = '{8'hA5, 8'h00, 8'h01};
        send_seq(q, "t5a");
        send_byte(8'h12, 1'b0);
        check_status("t5 frame_err");
        check("t5 lit err", 32'(err), 32'd1);
        check("t5 lit busy", 32'(busy), 32'd0);
        w0 = n_writes;
        glitch(1);
        glitch(4);
        check_status("t5 glitch idle");
        // Glitches inside a frame must not become an 0xFF length byte.
        q = '{8'hA5};
        send_seq(q, "t5b");
        glitch(1);
        glitch(4);
        q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        send_seq(q, "t5c");
        check("t5 lit done", 32'(done), 32'd1);
        check("t5 lit ram_wdata", 32'(ram_wdata), 32'h1234);
        check("t5 lit writes", 32'(n_writes - w0), 32'd1);

        // 6: reset mid-frame, then a fresh frame
        q = '{8'hA5, 8'h00, 8'h02, 8'h12};
        send_seq(q, "t6a");
        reset = 1'b0;
        model_reset();
        #1;
        check_all_zero("t6 reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_status("t6 after reset");
        q = '{8'hA5, 8'h00, 8'h01, 8'h55, 8'hAA, 8'hFF};
        send_seq(q, "t6b");
        check("t6 lit done", 32'(done), 32'd1);
        check("t6 lit ram_wdata", 32'(ram_wdata), 32'h55AA);
`ifndef UART_PROG_LOADER_CKSUM_EN
        w0 = n_writes;
        q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_seq(q, "t6c");
        check("t6c lit done", 32'(done), 32'd1);
        check("t6c lit writes", 32'(n_writes - w0), 32'd2);
        check("t6c lit ram_wdata", 32'(ram_wdata), 32'hABCD);
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
